// File: rtl/powlib_cntr_pkg.sv
// Shared helpers for the powlib counter family.
// FIFO users size counter widths with powlib_clogb2; the counter itself
// needs no package constants.
package powlib_cntr_pkg;

    // Number of bits needed to index 'value' distinct items (ceil(log2(value))).
    function automatic int powlib_clogb2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if (((value - 1) >> i) > 0) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/powlib_cntr_flipflop.sv
// powlib_flipflop: W-bit register with asynchronous reset to INIT and an
// optional capture enable.
module powlib_flipflop #(
    parameter int              W    = 16,
    parameter logic [W-1:0]    INIT = '0,
    parameter int              EVLD = 1,
    parameter int              EAR  = 0
) (
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    input  logic         vld,
    input  logic         clk,
    input  logic         rst
);
    import powlib_cntr_pkg::*;

    logic [W-1:0] data_q;
    logic         capture;

    // With EVLD=0 the register loads every cycle and vld is ignored.
    generate
        if (EVLD != 0) begin : g_vld
            assign capture = vld;
        end else begin : g_no_vld
            logic unused_vld;
            assign unused_vld = vld;
            assign capture    = 1'b1;
        end
        // EAR exists only so existing instantiations still elaborate; the
        // reset below is asynchronous whatever its value.
        if (EAR != 0) begin : g_ear_compat
        end
    endgenerate

    // State register: asynchronous reset to INIT, capture on enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= INIT;
        end else if (capture) begin
            data_q <= d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/powlib_cntr.sv
// powlib_cntr: W-bit up/down counter with clear, optional load and optional
// signed step. Used as FIFO pointer and fill-level tracker.
module powlib_cntr #(
    parameter int W    = 16,
    parameter int INIT = 0,
    parameter int ELD  = 1,
    parameter int EDX  = 0,
    parameter int EAR  = 0
) (
    input  logic         clk,
    input  logic         rst,
    output logic [W-1:0] cntr,
    input  logic         adv,
    input  logic         clr,
    input  logic [W-1:0] dx,
    input  logic         ld,
    input  logic [W-1:0] nval
);
    import powlib_cntr_pkg::*;

    // INIT may be given wider than the counter; only the low W bits matter.
    localparam logic [W-1:0] INIT_W = W'(INIT);

    logic [W-1:0] cntr_q;
    logic [W-1:0] cntr_d;
    logic [W-1:0] step;
    logic         ld_en;
    logic [W-1:0] ld_val;
    logic         upd;

    // Step source: constant 1, or the two's-complement dx input.
    generate
        if (EDX != 0) begin : g_step_dx
            assign step = dx;
        end else begin : g_step_one
            logic unused_dx;
            assign unused_dx = ^dx;
            assign step      = {{(W-1){1'b0}}, 1'b1};
        end
    endgenerate

    // Load path is removed entirely when ELD=0.
    generate
        if (ELD != 0) begin : g_load
            assign ld_en  = ld;
            assign ld_val = nval;
        end else begin : g_no_load
            logic unused_ld;
            assign unused_ld = ld ^ (^nval);
            assign ld_en     = 1'b0;
            assign ld_val    = '0;
        end
    endgenerate

    // Next count: clr beats ld beats adv; wrap is natural modulo 2^W.
    always_comb begin
        cntr_d = cntr_q;
        if (clr) begin
            cntr_d = INIT_W;
        end else if (ld_en) begin
            cntr_d = ld_val;
        end else if (adv) begin
            cntr_d = cntr_q + step;
        end
    end

    assign upd = clr | ld_en | adv;

    powlib_flipflop #(
        .W    (W),
        .INIT (INIT_W),
        .EVLD (1),
        .EAR  (EAR)
    ) u_reg (
        .d   (cntr_d),
        .q   (cntr_q),
        .vld (upd),
        .clk (clk),
        .rst (rst)
    );

    assign cntr = cntr_q;

endmodule

// File: tb/tb_powlib_cntr.sv
// Directed self-checking bench for powlib_cntr, several parameterisations
// sharing one clock.
module tb_powlib_cntr;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reset instance: W=4, INIT=5
    logic       rst_a, adv_a, clr_a, ld_a;
    logic [3:0] dx_a, nval_a, cntr_a;
    // Increment / clear / load instance: W=3, INIT=0, ELD=1, EDX=0
    logic       rst_b, adv_i, clr_i, ld_i;
    logic [2:0] dx_i, nval_i, cntr_i;
    // Signed step instance: W=3, EDX=1
    logic       adv_s, clr_s, ld_s;
    logic [2:0] dx_s, nval_s, cntr_s;
    // Clear-to-INIT=1 instance
    logic       adv_c, clr_c, ld_c;
    logic [2:0] dx_c, nval_c, cntr_c;
    // No-load instance: ELD=0
    logic       adv_n, clr_n, ld_n;
    logic [2:0] dx_n, nval_n, cntr_n;

    powlib_cntr #(.W(4), .INIT(5), .ELD(1), .EDX(0), .EAR(0)) u_rst (
        .clk(clk), .rst(rst_a), .cntr(cntr_a), .adv(adv_a), .clr(clr_a),
        .dx(dx_a), .ld(ld_a), .nval(nval_a));
    powlib_cntr #(.W(3), .INIT(0), .ELD(1), .EDX(0), .EAR(0)) u_inc (
        .clk(clk), .rst(rst_b), .cntr(cntr_i), .adv(adv_i), .clr(clr_i),
        .dx(dx_i), .ld(ld_i), .nval(nval_i));
    powlib_cntr #(.W(3), .INIT(0), .ELD(1), .EDX(1), .EAR(0)) u_step (
        .clk(clk), .rst(rst_b), .cntr(cntr_s), .adv(adv_s), .clr(clr_s),
        .dx(dx_s), .ld(ld_s), .nval(nval_s));
    powlib_cntr #(.W(3), .INIT(1), .ELD(1), .EDX(0), .EAR(1)) u_clr1 (
        .clk(clk), .rst(rst_b), .cntr(cntr_c), .adv(adv_c), .clr(clr_c),
        .dx(dx_c), .ld(ld_c), .nval(nval_c));
    powlib_cntr #(.W(3), .INIT(0), .ELD(0), .EDX(0), .EAR(0)) u_nold (
        .clk(clk), .rst(rst_b), .cntr(cntr_n), .adv(adv_n), .clr(clr_n),
        .dx(dx_n), .ld(ld_n), .nval(nval_n));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
        $display("check %-14s observed %0d expected %0d", tag, obs, exp);
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [2:0] inc_exp [9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
    logic [2:0] stp_dx  [8] = '{3'd1, 3'd1, 3'd1, 3'd7, 3'd7, 3'd0, 3'd7, 3'd7};
    logic [2:0] stp_exp [8] = '{3'd1, 3'd2, 3'd3, 3'd2, 3'd1, 3'd1, 3'd0, 3'd7};

    initial begin
        rst_a = 0; adv_a = 0; clr_a = 0; ld_a = 0; dx_a = 0; nval_a = 0;
        rst_b = 0; adv_i = 0; clr_i = 0; ld_i = 0; dx_i = 0; nval_i = 0;
        adv_s = 0; clr_s = 0; ld_s = 0; dx_s = 0; nval_s = 0;
        adv_c = 0; clr_c = 0; ld_c = 0; dx_c = 0; nval_c = 0;
        adv_n = 0; clr_n = 0; ld_n = 0; dx_n = 0; nval_n = 0;

        // Reset state of every instance
        #2 rst_a = 1; rst_b = 1;
        #1;
        chk("rst_init_a", 32'(cntr_a), 32'd5);
        chk("rst_init_i", 32'(cntr_i), 32'd0);
        chk("rst_init_c", 32'(cntr_c), 32'd1);
        @(negedge clk);
        rst_a = 0; rst_b = 0;

        // Reset mid-count: load 9, then assert rst between edges
        ld_a = 1; nval_a = 4'd9;
        tick();
        chk("rst_load9", 32'(cntr_a), 32'd9);
        ld_a = 0; adv_a = 1;
        #2 rst_a = 1;
        #1 chk("rst_async", 32'(cntr_a), 32'd5);
        tick();
        chk("rst_held", 32'(cntr_a), 32'd5);
        #2 rst_a = 0;
        #1 chk("rst_no_edge", 32'(cntr_a), 32'd5);
        tick();
        chk("rst_first_upd", 32'(cntr_a), 32'd6);
        adv_a = 0;

        // Increment and wrap
        adv_i = 1;
        for (int k = 0; k < 9; k++) begin
            tick();
            chk("inc_wrap", 32'(cntr_i), 32'(inc_exp[k]));
        end
        adv_i = 0;

        // Clear beats advance at cntr=7
        ld_i = 1; nval_i = 3'd7;
        tick();
        chk("clr_pre7", 32'(cntr_i), 32'd7);
        ld_i = 0; adv_i = 1; clr_i = 1;
        tick();
        chk("clr_over_adv", 32'(cntr_i), 32'd0);
        adv_i = 0; clr_i = 0;

        // Clear alone to INIT=1
        adv_c = 1;
        tick();
        chk("clr1_adv", 32'(cntr_c), 32'd2);
        adv_c = 0; clr_c = 1;
        tick();
        chk("clr1_init", 32'(cntr_c), 32'd1);
        clr_c = 0;

        // Bring load and no-load instances to 2
        ld_i = 1; nval_i = 3'd2; adv_n = 1;
        tick();
        ld_i = 0;
        tick();
        chk("ld_pre_i", 32'(cntr_i), 32'd2);
        chk("ld_pre_n", 32'(cntr_n), 32'd2);
        // ld + adv: load wins when enabled, ignored when ELD=0
        ld_i = 1; nval_i = 3'd6; adv_i = 1;
        ld_n = 1; nval_n = 3'd6; adv_n = 1;
        tick();
        chk("ld_over_adv", 32'(cntr_i), 32'd6);
        chk("ld_disabled", 32'(cntr_n), 32'd3);
        ld_i = 0; ld_n = 0;
        tick();
        chk("ld_then_adv", 32'(cntr_i), 32'd7);
        chk("nold_adv", 32'(cntr_n), 32'd4);
        adv_i = 0; adv_n = 0;

        // Signed step sequence including dx=0 hold and downward wrap
        adv_s = 1;
        for (int k = 0; k < 8; k++) begin
            dx_s = stp_dx[k];
            tick();
            chk("step", 32'(cntr_s), 32'(stp_exp[k]));
        end
        adv_s = 0;

        // Hold with dx toggling randomly
        for (int k = 0; k < 10; k++) begin
            dx_s = 3'($urandom);
            dx_i = 3'($urandom);
            tick();
            chk("hold_step", 32'(cntr_s), 32'd7);
            chk("hold_inc", 32'(cntr_i), 32'd7);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/powlib_cntr.md
Name: powlib_cntr

Overview:
- Parameterised up/down counter register used as a FIFO pointer and as a fill-level tracker.
- Keeps a W-bit count. On each rising clk edge it can advance by 1 or by a signed step, synchronously clear to a preset value, or load an arbitrary value.
- Single clock domain; asynchronous active-high reset.

Parameters:
- W, 16, counter width in bits.
- INIT, 0, value after reset and after clr.
- ELD, 1, enable load path; when 0, ld/nval are ignored and their logic is removed.
- EDX, 0, enable step input; when 0 every advance adds 1, when 1 every advance adds dx.
- EAR, 0, accepted for instantiation compatibility only; reset is asynchronous regardless of its value.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- cntr  output  W  current count (registered).
- adv  input  1  advance request.
- clr  input  1  synchronous clear to INIT.
- dx  input  W  step, two's complement; used only when EDX=1.
- ld  input  1  synchronous load request; used only when ELD=1.
- nval  input  W  value to load; used only when ELD=1.

Behaviour:
- Reset: rst high forces cntr=INIT immediately, with no clock edge needed, and holds it while rst is high. The first update happens on the first rising clk edge after rst deasserts.
- Priority at each rising edge, highest first:
  - clr: cntr <= INIT.
  - ld (ELD=1): cntr <= nval.
  - adv: cntr <= cntr + step.
  - otherwise: hold.
- step is 1 when EDX=0, and dx when EDX=1.
- Arithmetic is modulo 2^W; wrap in both directions, no saturation, no overflow flag.
  - Example: W=3, cntr=7, +1 gives 0.
  - Example: cntr=0, dx=all-ones (-1) gives all-ones.
- clr asserted together with adv: clr wins (FIFO pointer wrap relies on this). Same for clr with ld.
- ld asserted together with adv: ld wins; no advance is applied to nval.
- dx=0 with adv=1: counter holds.
- Latency: every change appears on cntr one cycle after the edge. cntr is driven directly from the register; there is no combinational path from any input to cntr.
- Unused inputs (dx when EDX=0; ld/nval when ELD=0) must have no effect and may be left unconnected or tied to 0.
- INIT is truncated to W bits.

Decomposition:
- Shared package / std include: the powlib_clogb2 helper that FIFO users apply to size W (no package constants needed by this block itself).
- One sub-module is natural: powlib_flipflop, a W-bit register.
  - Parameters: W, INIT, EVLD, EAR.
  - Ports: d, q, vld, clk, rst.
  - Behaviour: asynchronous reset to INIT; captures d when vld=1 (EVLD=1).
- The counter computes next-state combinationally and drives the flipflop with vld = clr|ld|adv.

Test Plan:
- Reset/init: W=4, INIT=5; assert rst mid-count (cntr=9) between clock edges -> cntr=5 immediately, stays 5 until the first edge after release.
- Increment and wrap: W=3, EDX=0, adv=1 for 9 cycles from 0 -> 1,2,...,7,0,1.
- Signed step: W=3, EDX=1; from 0, adv with dx=1 three times then dx=7 (-1) twice -> 1,2,3,2,1; adv with dx=0 -> holds 1.
- Clear priority: W=3, cntr=7, adv=1 and clr=1 on the same edge -> 0 (INIT), not wrap-increment; clr alone with INIT=1 -> 1.
- Load: ELD=1, cntr=2, ld=1, nval=6, adv=1 -> 6; next edge with adv only -> 7. With ELD=0 the same stimulus -> 3.
- Hold: adv=clr=ld=0 for 10 cycles with dx toggling randomly -> cntr unchanged.
